// File: rtl/spi_burst_controller_pkg.sv
// Shared opcodes, register areas, FSM state encoding and STATUS bit positions
// for the SPI burst controller.
package spi_burst_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_ENABLE  = 8'h81;
    localparam logic [7:0] CMD_STREAM  = 8'h82;
    localparam logic [7:0] CMD_DISABLE = 8'h83;

    localparam logic [1:0] AREA_CONTROL = 2'b00;
    localparam logic [1:0] AREA_CHAR    = 2'b01;
    localparam logic [1:0] AREA_MASK    = 2'b10;
    localparam logic [1:0] AREA_RESULT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_LEN,
        ST_DATA
    } state_t;

    localparam int STATUS_ENABLED_BIT = 0;
    localparam int STATUS_ACTIVE_BIT  = 1;
    localparam int STATUS_OVF_BIT     = 2;

endpackage

// File: rtl/spi_burst_controller_if.sv
// AXI-Stream byte channel from the controller to the search core.
// SPI_BURST_TREADY_EN adds the tready back-pressure signal.
interface spi_burst_controller_if;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tuser;
    logic       tlast;
`ifdef SPI_BURST_TREADY_EN
    logic       tready;

    modport master (output tvalid, tdata, tuser, tlast, input  tready);
    modport slave  (input  tvalid, tdata, tuser, tlast, output tready);
`else
    modport master (output tvalid, tdata, tuser, tlast);
    modport slave  (input  tvalid, tdata, tuser, tlast);
`endif
endinterface

// File: rtl/spi_burst_stream_framer.sv
// Length-framed stream beat generator: burst counter, tvalid/tuser/tlast and
// the sticky overflow flag. SPI_BURST_TREADY_EN enables holding on !tready.
module spi_burst_stream_framer (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       start,
    input  logic [7:0] len,
    input  logic       beat_strobe,
    input  logic [7:0] beat_data,
    input  logic       ovf_clr,
    output logic       stream_active,
    output logic       last_beat,
    output logic       overflow,
    spi_burst_controller_if.master m_axis
);

    logic [8:0] count_q;
    logic       hold;

`ifdef SPI_BURST_TREADY_EN
    assign hold = m_axis.tvalid && !m_axis.tready;
`else
    assign hold = 1'b0;
`endif

    assign stream_active = (count_q != 9'd0);
    assign last_beat     = (count_q == 9'd1);

    // NOTE: every sequential signal uses <= so all registers update from the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            count_q       <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tuser  <= 1'b0;
            m_axis.tlast  <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (ovf_clr) overflow <= 1'b0;
            if (!hold) m_axis.tvalid <= 1'b0;

            if (!cs) begin
                // Aborted burst: drop the counter and any pending beat, no tlast.
                count_q       <= '0;
                m_axis.tvalid <= 1'b0;
                m_axis.tlast  <= 1'b0;
            end else if (start) begin
                count_q <= (len == 8'd0) ? 9'd256 : {1'b0, len};
            end else if (beat_strobe) begin
                count_q <= count_q - 9'd1;
                if (hold) begin
                    overflow <= 1'b1;
                end else begin
                    m_axis.tvalid <= 1'b1;
                    m_axis.tdata  <= beat_data;
                    m_axis.tuser  <= (beat_data == 8'h00);
                    m_axis.tlast  <= (count_q == 9'd1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_burst_controller.sv
// Byte-per-clock SPI command decoder owning the lane configuration registers
// and feeding the search core stream. SPI_BURST_TREADY_EN adds stream tready.
module spi_burst_controller
    import spi_burst_pkg::*;
#(
    parameter int NUM_LANES = 8
) (
    input  logic                   sclk,
    input  logic                   rst_n,
    input  logic                   cs,
    input  logic [7:0]             mosi,
    output logic [7:0]             miso,
    output logic [7:0]             word_size,
    output logic [NUM_LANES-1:0]   result_mask,
    output logic [8*NUM_LANES-1:0] characters,
    output logic [8*NUM_LANES-1:0] masks,
    input  logic [8*NUM_LANES-1:0] result_ids,
    output logic                   aclk,
    output logic                   aresetn,
    spi_burst_controller_if.master m_axis
);

    localparam int LANE_W     = $clog2(NUM_LANES);
    localparam int MASK_BYTES = (NUM_LANES + 7) / 8;
    localparam logic [LANE_W-1:0] MASK_LAST  = LANE_W'(MASK_BYTES);
    localparam logic [LANE_W-1:0] STATUS_OFF = LANE_W'(MASK_BYTES + 1);

    state_t              state_q, state_d;
    logic [1:0]          area_q, area_d;
    logic [LANE_W-1:0]   offset_q, offset_d;
    logic [1:0]          rd_area;
    logic [LANE_W-1:0]   rd_off;
    logic [7:0]          rd_data, status;
    logic                reg_wr, rd_load, st_start, st_beat, en_set, en_clr;
    logic                stream_active, last_beat, overflow, ovf_clr;
    logic [MASK_BYTES*8-1:0] mask_pad, mask_wr;

    assign aclk     = sclk;
    assign mask_pad = (MASK_BYTES*8)'(result_mask);
    assign ovf_clr  = rd_load && (rd_area == AREA_CONTROL) && (rd_off == STATUS_OFF);

    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        area_d   = area_q;
        offset_d = offset_q;
        rd_area  = area_q;
        rd_off   = offset_q;
        reg_wr   = 1'b0;
        rd_load  = 1'b0;
        st_start = 1'b0;
        st_beat  = 1'b0;
        en_set   = 1'b0;
        en_clr   = 1'b0;
        if (!cs) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    case (mosi)
                        CMD_WRITE:   state_d = ST_WR_ADDR;
                        CMD_READ:    state_d = ST_RD_ADDR;
                        CMD_STREAM:  state_d = ST_LEN;
                        CMD_ENABLE:  en_set  = 1'b1;
                        CMD_DISABLE: en_clr  = 1'b1;
                        default:     state_d = ST_IDLE;
                    endcase
                end
                ST_WR_ADDR: begin
                    area_d   = mosi[LANE_W+1:LANE_W];
                    offset_d = mosi[LANE_W-1:0];
                    state_d  = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    reg_wr   = 1'b1;
                    offset_d = offset_q + 1'b1;
                end
                ST_RD_ADDR: begin
                    rd_area  = mosi[LANE_W+1:LANE_W];
                    rd_off   = mosi[LANE_W-1:0];
                    rd_load  = 1'b1;
                    area_d   = rd_area;
                    offset_d = rd_off + 1'b1;
                    state_d  = ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    rd_load  = 1'b1;
                    offset_d = offset_q + 1'b1;
                end
                ST_LEN: begin
                    st_start = 1'b1;
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    st_beat = 1'b1;
                    if (last_beat) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        status                     = '0;
        status[STATUS_ENABLED_BIT] = aresetn;
        status[STATUS_ACTIVE_BIT]  = stream_active;
        status[STATUS_OVF_BIT]     = overflow;
        rd_data = '0;
        mask_wr = mask_pad;
        for (int b = 0; b < MASK_BYTES; b++) begin
            if (offset_q == LANE_W'(b + 1)) mask_wr[8*b +: 8] = mosi;
        end
        case (rd_area)
            AREA_CONTROL: begin
                if (rd_off == '0) rd_data = word_size;
                else if (rd_off == STATUS_OFF) rd_data = status;
                for (int b = 0; b < MASK_BYTES; b++) begin
                    if (rd_off == LANE_W'(b + 1)) rd_data = mask_pad[8*b +: 8];
                end
            end
            AREA_CHAR:   rd_data = characters[{rd_off, 3'b000} +: 8];
            AREA_MASK:   rd_data = masks[{rd_off, 3'b000} +: 8];
            AREA_RESULT: rd_data = result_ids[{rd_off, 3'b000} +: 8];
            default:     rd_data = '0;
        endcase
    end

    // NOTE: the lane registers are a handful of flops, not a RAM, so they are
    // all cleared by the synchronous reset.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            area_q      <= '0;
            offset_q    <= '0;
            miso        <= '0;
            word_size   <= '0;
            result_mask <= '0;
            characters  <= '0;
            masks       <= '0;
            aresetn     <= 1'b0;
        end else begin
            state_q  <= state_d;
            area_q   <= area_d;
            offset_q <= offset_d;
            if (en_set)  aresetn <= 1'b1;
            if (en_clr)  aresetn <= 1'b0;
            if (rd_load) miso    <= rd_data;
            if (reg_wr) begin
                case (area_q)
                    AREA_CONTROL: begin
                        if (offset_q == '0) word_size <= mosi;
                        else if (offset_q <= MASK_LAST) result_mask <= mask_wr[NUM_LANES-1:0];
                    end
                    AREA_CHAR: characters[{offset_q, 3'b000} +: 8] <= mosi;
                    AREA_MASK: masks[{offset_q, 3'b000} +: 8]      <= mosi;
                    default:   ;
                endcase
            end
        end
    end

    spi_burst_stream_framer u_framer (
        .sclk          (sclk),
        .rst_n         (rst_n),
        .cs            (cs),
        .start         (st_start),
        .len           (mosi),
        .beat_strobe   (st_beat),
        .beat_data     (mosi),
        .ovf_clr       (ovf_clr),
        .stream_active (stream_active),
        .last_beat     (last_beat),
        .overflow      (overflow),
        .m_axis        (m_axis)
    );

endmodule

// File: tb/tb_spi_burst_controller.sv
// Scoreboard bench for spi_burst_controller (NUM_LANES=8): directed SPI byte
// sequences, queued expectations for miso reads and stream beats.
module tb_spi_burst_controller;

    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic [7:0]  mosi = '0;
    logic [7:0]  miso, word_size;
    logic [7:0]  result_mask;
    logic [63:0] characters, masks;
    logic [63:0] result_ids = '0;
    logic        aclk, aresetn;

    spi_burst_controller_if axis ();

`ifdef SPI_BURST_TREADY_EN
    assign axis.tready = 1'b1;
`endif

    spi_burst_controller #(.NUM_LANES(8)) dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .word_size   (word_size),
        .result_mask (result_mask),
        .characters  (characters),
        .masks       (masks),
        .result_ids  (result_ids),
        .aclk        (aclk),
        .aresetn     (aresetn),
        .m_axis      (axis)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_miso[$];
    logic [9:0] exp_beat[$];   // {tdata, tuser, tlast}
    logic       miso_tag = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one byte; when cap is set the read byte returned for it is queued.
    task automatic send(input logic [7:0] b, input bit cap = 1'b0, input logic [7:0] exp = 8'h00);
        @(negedge sclk);
        cs = 1'b1;
        mosi = b;
        miso_tag = cap;
        if (cap) exp_miso.push_back(exp);
        @(posedge sclk);
    endtask

    task automatic sbeat(input logic [7:0] b, input bit user, input bit last);
        @(negedge sclk);
        cs = 1'b1;
        mosi = b;
        miso_tag = 1'b0;
        exp_beat.push_back({b, user, last});
        @(posedge sclk);
    endtask

    task automatic gap(input int n = 1);
        repeat (n) begin
            @(negedge sclk);
            cs = 1'b0;
            mosi = 8'h00;
            miso_tag = 1'b0;
            @(posedge sclk);
        end
        #1;
    endtask

    // Monitor: samples just after each edge and retires queued expectations.
    always @(posedge sclk) begin
        #1;
        if (axis.tvalid) begin
            if (exp_beat.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat_unexpected: got tdata=%h tlast=%b with no beat expected", axis.tdata, axis.tlast);
            end else begin
                check("beat", {54'd0, axis.tdata, axis.tuser, axis.tlast}, {54'd0, exp_beat.pop_front()});
            end
        end
        if (miso_tag) begin
            if (exp_miso.size() == 0) begin
                total++;
                bad++;
                $display("FAIL miso_unexpected: got %h with no read expected", miso);
            end else begin
                check("miso", {56'd0, miso}, {56'd0, exp_miso.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        check("rst_miso", {56'd0, miso}, 64'd0);
        check("rst_word_size", {56'd0, word_size}, 64'd0);
        check("rst_result_mask", {56'd0, result_mask}, 64'd0);
        check("rst_characters", characters, 64'd0);
        check("rst_masks", masks, 64'd0);
        check("rst_aresetn", {63'd0, aresetn}, 64'd0);
        check("rst_axis", {54'd0, axis.tvalid, axis.tdata, axis.tlast}, 64'd0);
        check("rst_tuser", {63'd0, axis.tuser}, 64'd0);
        @(negedge sclk);
        rst_n = 1'b1;
        gap(1);

        // Burst write into CHAR lanes 0..2
        send(8'h02); send(8'h08); send(8'h41); send(8'h42); send(8'h43);
        gap(1);
        check("burst_write", characters, 64'h0000_0000_0043_4241);

        // Offset wraps lane 7 -> lane 0 inside CHAR area
        send(8'h02); send(8'h0F); send(8'hAA); send(8'hBB);
        gap(1);
        check("wrap_write", characters, 64'hAA00_0000_0043_42BB);
        check("wrap_masks", masks, 64'd0);

        // CONTROL: word_size, result_mask, STATUS write ignored
        send(8'h02); send(8'h00); send(8'h05); send(8'h3C); send(8'h77);
        gap(1);
        check("word_size", {56'd0, word_size}, 64'h05);
        check("result_mask", {56'd0, result_mask}, 64'h3C);

        send(8'h02); send(8'h17); send(8'h99);
        gap(1);
        check("mask_lane7", masks, 64'h9900_0000_0000_0000);

        // Burst reads
        result_ids = 64'h0000_0000_0000_2211;
        send(8'h03); send(8'h18, 1'b1, 8'h11); send(8'h00, 1'b1, 8'h22);
        gap(1);
        send(8'h03); send(8'h00, 1'b1, 8'h05); send(8'hFF, 1'b1, 8'h3C);
        send(8'hFF, 1'b1, 8'h00); send(8'hFF, 1'b1, 8'h00);
        gap(1);
        send(8'h03); send(8'h0F, 1'b1, 8'hAA); send(8'h00, 1'b1, 8'hBB);
        gap(1);
        check("miso_hold", {56'd0, miso}, 64'hBB);

        // Enable then a 3-byte framed stream
        send(8'h81);
        send(8'h82); send(8'h03);
        sbeat(8'h05, 1'b0, 1'b0); sbeat(8'h00, 1'b1, 1'b0); sbeat(8'h07, 1'b0, 1'b1);
        gap(1);
        check("aresetn_on", {63'd0, aresetn}, 64'd1);
        check("tvalid_idle", {63'd0, axis.tvalid}, 64'd0);
        send(8'h03); send(8'h02, 1'b1, 8'h01);
        gap(1);

        // Aborted stream: one beat, no tlast
        send(8'h82); send(8'h04); sbeat(8'h09, 1'b0, 1'b0);
        gap(2);
        check("abort_tvalid", {63'd0, axis.tvalid}, 64'd0);
        send(8'h03); send(8'h02, 1'b1, 8'h01);
        gap(1);

        // Length 0 means a 256-byte burst
        send(8'h82); send(8'h00);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = i[7:0];
            sbeat(d, i == 0, i == 255);
        end
        gap(1);
        send(8'h03); send(8'h02, 1'b1, 8'h01);
        gap(1);

        // Disable clears aresetn; STATUS reflects it
        send(8'h83);
        gap(1);
        check("aresetn_off", {63'd0, aresetn}, 64'd0);
        send(8'h03); send(8'h02, 1'b1, 8'h00);
        gap(1);

        // Reset in the middle of a write burst
        send(8'h81);
        send(8'h02); send(8'h10);
        @(negedge sclk);
        cs = 1'b1;
        mosi = 8'hEE;
        rst_n = 1'b0;
        @(posedge sclk);
        #1;
        check("midrst_characters", characters, 64'd0);
        check("midrst_masks", masks, 64'd0);
        check("midrst_ctrl", {40'd0, word_size, result_mask, miso}, 64'd0);
        check("midrst_aresetn", {63'd0, aresetn}, 64'd0);
        @(negedge sclk);
        rst_n = 1'b1;

        // Unknown opcode keeps the FSM idle; following bytes decode as opcodes
        send(8'h55); send(8'h08); send(8'h77);
        gap(1);
        check("bad_opcode", characters, 64'd0);
        send(8'h02); send(8'h08); send(8'h66);
        gap(1);
        check("after_bad_opcode", characters, 64'h0000_0000_0000_0066);

        gap(2);
        check("beat_queue_empty", 64'(exp_beat.size()), 64'd0);
        check("miso_queue_empty", 64'(exp_miso.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_burst_controller.md
Name: spi_burst_controller

Overview:
Byte-per-clock command decoder between the host SPI front end and the word-search core. It is a parametrised successor to the single-byte controller, with NUM_LANES character lanes and burst register reads/writes with address auto-increment. It adds length-framed AXI-Stream bursts with tlast and a read-only status register. It owns the lane configuration registers and drives the search core's stream input and reset.

Parameters:
NUM_LANES, 8, number of character lanes; legal values 8, 16, 32.
LANE_W, $clog2(NUM_LANES), localparam; lane-offset field width.
MASK_BYTES, (NUM_LANES+7)/8, localparam; bytes holding result_mask.

Ports:
sclk  input  1  clock; also forwarded as aclk
rst_n  input  1  synchronous active-low reset
cs  input  1  transaction select, active high; 0 forces IDLE
mosi  input  8  command/address/data byte, one per sclk
miso  output  8  registered read data
word_size  output  8  search word length register
result_mask  output  NUM_LANES  per-lane result enable
characters  output  8*NUM_LANES  lane character registers, lane i = bits [8i+7:8i]
masks  output  8*NUM_LANES  lane mask registers
result_ids  input  8*NUM_LANES  per-lane result bytes, read-only
aclk  output  1  = sclk
aresetn  output  1  core reset, active low
m_axis_tvalid  output  1  stream byte valid
m_axis_tdata  output  8  stream byte
m_axis_tuser  output  1  1 when tdata == 8'h00
m_axis_tlast  output  1  final byte of a framed burst

Behaviour:
- Reset: rst_n sampled on posedge sclk, synchronous, active-low. All outputs and registers go to 0: miso, word_size, result_mask, characters, masks, aresetn, tvalid, tdata, tuser, tlast, overflow flag. State goes to IDLE. Reset mid-transaction aborts it with no tlast.
- Opcodes, decoded in IDLE with cs=1: 0x02 WRITE, 0x03 READ, 0x81 ENABLE (aresetn<=1), 0x82 STREAM, 0x83 DISABLE (aresetn<=0). Any other opcode is ignored and the FSM stays in IDLE.
- Address byte layout: [LANE_W+1:LANE_W] area, [LANE_W-1:0] offset. Higher bits are ignored.
- Areas: 00 CONTROL, 01 CHAR, 10 MASK, 11 RESULT.
- CONTROL offsets:
  - 0: word_size.
  - 1..MASK_BYTES: result_mask bytes, little-endian. Unused high bits read 0 and are discarded on write.
  - MASK_BYTES+1: STATUS, read-only = {5'b0, overflow, stream_active, aresetn}.
  - All other offsets read 0x00; writes to them are ignored.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, ST_LEN, ST_DATA.
- WRITE sequence:
  - IDLE(0x02) -> WR_ADDR; the next byte latches addr -> WR_DATA.
  - Each WR_DATA byte writes reg[addr], then the offset increments.
  - The offset wraps NUM_LANES-1 -> 0 within the same area; the area never changes.
  - Writes to the RESULT area and to STATUS are ignored but still increment.
- READ sequence:
  - IDLE(0x03) -> RD_ADDR. On the address byte, miso<=reg[addr] and offset<=addr.offset+1 -> RD_DATA.
  - Each RD_DATA cycle: miso<=reg[offset], offset++ with the same wrap rule. mosi is don't-care.
  - Latency is one clock from the address byte to the first miso byte. miso holds its value while in IDLE.
- STREAM sequence:
  - IDLE(0x82) -> ST_LEN. The length byte L gives the count; L=0 means 256. Load counter -> ST_DATA and set stream_active=1.
  - Each ST_DATA byte: tdata<=mosi, tvalid<=1, tuser<=(mosi==0), tlast<=(count==1); count--.
  - After count reaches 0: IDLE and stream_active=0.
  - tvalid is a one-cycle pulse per byte. It is 0 on any cycle not in ST_DATA.
- cs=0 at any edge: state<=IDLE and tvalid<=0. Register contents, aresetn and miso are kept. An aborted stream emits no tlast and clears stream_active.
- The opcode byte is always consumed. Sending 0x81/0x83 inside a burst has no command meaning; the byte is treated as data.

Optional Feature:
SPI_BURST_TREADY_EN: adds input m_axis_tready (1 bit).
- With the macro: a beat is held while tvalid&&!tready. A new ST_DATA byte arriving during the hold is dropped and sets sticky overflow=1. The counter still decrements.
- overflow is cleared only by reading STATUS (clear-on-read) or by reset.
- Without the macro: no tready port, tvalid pulses as above, overflow is constant 0.

Decomposition:
- Package spi_burst_pkg holds:
  - opcode localparams CMD_*;
  - area codes AREA_CONTROL/CHAR/MASK/RESULT;
  - the state enum (3 bits);
  - the STATUS bit positions.
- Sub-module spi_burst_stream_framer holds the length counter plus the tvalid/tuser/tlast/tready/overflow logic. The main FSM drives it with start/len/byte strobes.

Test Plan:
- Burst write, NUM_LANES=8: cs=1, 02 08 41 42 43 -> characters[7:0]=0x41, [15:8]=0x42, [23:16]=0x43; other lanes remain 0.
- Wrap: 02 0F AA BB -> characters lane7=0xAA, lane0=0xBB; masks unchanged.
- Burst read: set result_ids lane0..1 = 0x11,0x22. Send 03 18 xx -> miso=0x11 one cycle after the address byte, then 0x22.
- Stream: 81 then 82 03 05 00 07 -> three tvalid pulses with tdata 05,00,07, tuser 0,1,0, tlast 0,0,1. aresetn=1; STATUS reads 0x01.
- Abort: 82 04 09 then cs=0 -> one beat only, tlast never asserted, state IDLE. Next 03 02 returns STATUS with stream_active=0.
- Reset mid-write: 02 10 then rst_n=0 for 1 clock -> all registers 0. Next 0x55 byte with cs=1 is ignored as an opcode.
